// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial magnitude comparator: walks a 1-bit compare cell over two captured
// operands MSB first and reports registered L/G/E flags with a one-cycle done pulse.
module serial_mag_comp_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             G,
  output logic             E,
  output logic [IW-1:0]    bit_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ra_q, rb_q;
  logic [IW-1:0]    idx_q;
  logic             seen_q, gt_seen_q;
  logic             busy_q, done_q, l_q, g_q, e_q;

  logic cell_g, cell_l, gt_fin, lt_fin;

  assign cell_g = ra_q[idx_q] & ~rb_q[idx_q];
  assign cell_l = ~ra_q[idx_q] & rb_q[idx_q];
  // The first differing bit wins; lower bits only matter if nothing was seen yet.
  assign gt_fin = seen_q ? gt_seen_q  : cell_g;
  assign lt_fin = seen_q ? ~gt_seen_q : cell_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      idx_q     <= '0;
      seen_q    <= 1'b0;
      gt_seen_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      l_q       <= 1'b0;
      g_q       <= 1'b0;
      e_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            idx_q   <= IW'(WIDTH - 1);
            seen_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (EARLY_EXIT != 0 && (cell_g || cell_l)) begin
            l_q     <= cell_l;
            g_q     <= cell_g;
            e_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (idx_q == '0) begin
            l_q     <= lt_fin;
            g_q     <= gt_fin;
            e_q     <= ~(lt_fin | gt_fin);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
            if (!seen_q && (cell_g || cell_l)) begin
              seen_q    <= 1'b1;
              gt_seen_q <= cell_g;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign L       = l_q;
  assign G       = g_q;
  assign E       = e_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Bench for serial_mag_comp_ctrl: runs an early-exit and a full-scan instance side by
// side on the same stimulus and checks them against a plain-arithmetic model.
module tb_serial_mag_comp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;

  logic       e0_busy, e0_done, e0_L, e0_G, e0_E;
  logic       e1_busy, e1_done, e1_L, e1_G, e1_E;
  logic [2:0] e0_idx, e1_idx;

  int checks = 0;
  int errors = 0;
  logic [2:0] prev_flags = 3'b000;  // {L,G,E} the model says should be held

  always #5 clk = ~clk;

  serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(e0_busy), .done(e0_done), .L(e0_L), .G(e0_G), .E(e0_E), .bit_idx(e0_idx));

  serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(e1_busy), .done(e1_done), .L(e1_L), .G(e1_G), .E(e1_E), .bit_idx(e1_idx));

  // Edges from the accepting edge to the edge that first samples done high.
  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y, input bit ee);
    int k;
    if (!ee || x == y) return 9;
    k = 0;
    for (int i = 0; i < 8; i++) if (x[i] != y[i]) k = i;
    return (8 - k) + 1;
  endfunction

  // One transaction on both instances; every cycle checks busy/done/flags/bit_idx.
  task automatic run_txn(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                         input bit disturb);
    logic [2:0] nf, obs, expf;
    logic       od, ob;
    logic [2:0] oi;
    int         lat;
    int         ndone [2];
    nf = {ta < tb_v, ta > tb_v, ta == tb_v};
    ndone[0] = 0; ndone[1] = 0;
    @(negedge clk); a = ta; b = tb_v; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      for (int u = 0; u < 2; u++) begin
        lat  = exp_lat(ta, tb_v, u == 1);
        obs  = (u == 0) ? {e0_L, e0_G, e0_E} : {e1_L, e1_G, e1_E};
        od   = (u == 0) ? e0_done : e1_done;
        ob   = (u == 0) ? e0_busy : e1_busy;
        oi   = (u == 0) ? e0_idx  : e1_idx;
        expf = (n >= lat) ? nf : prev_flags;
        if (od) ndone[u]++;
        checks += 3;
        if (od !== (n == lat)) begin
          errors++;
          $display("FAIL %s ee=%0d cycle %0d done: got %b want %b", name, u, n, od, n == lat);
        end
        if (ob !== (n <= lat)) begin
          errors++;
          $display("FAIL %s ee=%0d cycle %0d busy: got %b want %b", name, u, n, ob, n <= lat);
        end
        if (obs !== expf) begin
          errors++;
          $display("FAIL %s ee=%0d cycle %0d LGE: got %b want %b", name, u, n, obs, expf);
        end
        if (n < lat) begin
          checks++;
          if (oi !== 3'(8 - n)) begin
            errors++;
            $display("FAIL %s ee=%0d cycle %0d bit_idx: got %0d want %0d", name, u, n, oi, 8 - n);
          end
        end
      end
      if (disturb && n == 3) begin start = 1'b1; a = 8'hFF; end
      if (disturb && n == 4) start = 1'b0;
      @(negedge clk);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ndone[u] != 1) begin
        errors++;
        $display("FAIL %s ee=%0d done count: got %0d want 1", name, u, ndone[u]);
      end
    end
    prev_flags = nf;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({e0_busy, e0_done, e0_L, e0_G, e0_E, e0_idx,
         e1_busy, e1_done, e1_L, e1_G, e1_E, e1_idx} !== 16'h0) begin
      errors++;
      $display("FAIL %s: full busy/done/LGE/idx=%b%b%b%b%b/%0d early=%b%b%b%b%b/%0d want all 0",
               name, e0_busy, e0_done, e0_L, e0_G, e0_E, e0_idx,
               e1_busy, e1_done, e1_L, e1_G, e1_E, e1_idx);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");
  endtask

  task automatic test_reset_midrun;
    @(negedge clk); a = 8'hA5; b = 8'hA4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_midscan");
    @(negedge clk); rst_n = 1'b1;
    prev_flags = 3'b000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_zero("no_done_after_abort");
    end
  endtask

  task automatic test_msb_diff;    run_txn("msb_diff_80_7F", 8'h80, 8'h7F, 1'b0); endtask
  task automatic test_equal;       run_txn("equal_5A", 8'h5A, 8'h5A, 1'b0); endtask
  task automatic test_lsb_diff;    run_txn("lsb_diff_12_13", 8'h12, 8'h13, 1'b0); endtask
  task automatic test_disturb;     run_txn("start_and_a_midscan", 8'h3C, 8'h3C, 1'b1); endtask

  task automatic test_back_to_back;
    run_txn("b2b_first", 8'h01, 8'h00, 1'b0);
    run_txn("b2b_second", 8'h00, 8'h01, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_txn("random", ra, rb, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_msb_diff;
    test_equal;
    test_lsb_diff;
    test_disturb;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
